// File: rtl/div_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the EX-stage divide sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_ctrl_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    // Magnitude of a possibly signed word. 0x80000000 maps to itself, which is
    // the correct magnitude when read as unsigned, so no extra bit is needed.
    function automatic logic [RegBus-1:0] abs_val(input logic is_signed,
                                                  input logic [RegBus-1:0] v);
        return (is_signed && v[RegBus-1]) ? (ZeroWord - v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring-division iteration: shift {rem,quo} left, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   rem_in, quo_in : current partial remainder and quotient/dividend shift register
//   divisor        : divisor magnitude
//   rem_out, quo_out : values after one step
module div_step
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = RegBus
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic [DATA_W-1:0] quo_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic [DATA_W-1:0] quo_out
);

    // The shifted remainder can need DATA_W+1 bits because rem < divisor.
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;
    logic            borrow;

    assign shifted = {rem_in, quo_in[DATA_W-1]};
    assign diff    = shifted - {1'b0, divisor};
    // Top bit of the difference is set exactly when shifted < divisor.
    assign borrow  = diff[DATA_W];

    assign rem_out = borrow ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    assign quo_out = {quo_in[DATA_W-2:0], ~borrow};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit signed/unsigned restoring divide sequencer for the EX stage.
// Latency: ready_o 34 edges after start_i is sampled (2 for divide-by-zero / early out).
// Backpressure: EX holds start_i high until it consumes the result; dropping start_i releases it.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   signed_div_i    : 1 = DIV (signed), 0 = DIVU
//   opdata1_i/2_i   : dividend / divisor, only sampled in FREE
//   start_i         : request, held high until result consumed
//   annul_i         : flush; aborts a running divide
//   result_o        : {remainder (HI), quotient (LO)}, registered
//   ready_o         : result valid, registered
// Optional build macro DIV_EARLY_OUT_EN: finish in 2 edges when |dividend| < |divisor|.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    div_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] divisor;
    logic              neg_quo;
    logic              neg_rem;

    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_nxt;
    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;

    assign mag1 = abs_val(signed_div_i, opdata1_i);
    assign mag2 = abs_val(signed_div_i, opdata2_i);

    // Sign correction uses the signs captured at acceptance, not the live inputs.
    assign quo_fix = neg_quo ? (ZeroWord - quo) : quo;
    assign rem_fix = neg_rem ? (ZeroWord - rem) : rem;

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (divisor),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= '0;
                    if (start_i == DivStart && !annul_i) begin
                        divisor <= mag2;
                        quo     <= mag1;
                        rem     <= '0;
                        cnt     <= '0;
                        neg_quo <= signed_div_i &&
                                   (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_rem <= signed_div_i && opdata1_i[DATA_W-1];
                        if (opdata2_i == ZeroWord) begin
                            state <= DivByZero;
`ifdef DIV_EARLY_OUT_EN
                        end else if (mag1 < mag2) begin
                            // Quotient is zero and the remainder is the dividend itself;
                            // ready_o follows one edge later from END.
                            state    <= DivEnd;
                            result_o <= {opdata1_i, ZeroWord};
`endif
                        end else begin
                            state <= DivOn;
                        end
                    end
                end

                DivByZero: begin
                    state    <= DivEnd;
                    result_o <= '0;
                    ready_o  <= DivResultReady;
                end

                DivOn: begin
                    if (annul_i) begin
                        state    <= DivFree;
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                    end else if (cnt == CNT_W'(DATA_W)) begin
                        state    <= DivEnd;
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= DivResultReady;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DivEnd: begin
                    if (start_i == DivStop || annul_i) begin
                        state    <= DivFree;
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                    end else begin
                        ready_o <= DivResultReady;
                    end
                end

                default: begin
                    state <= DivFree;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized and directed check of div_ctrl against a plain-arithmetic divide model.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {remainder, quotient} using the language's own division.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (!s) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] mag(input logic s, input logic [31:0] v);
        return (s && v[31]) ? (32'd0 - v) : v;
    endfunction

    function automatic int exp_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
        if (mag(s, a) < mag(s, b)) return 2;
`endif
        return 34;
    endfunction

    // Issue one divide, measure latency, check result, hold, then release.
    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b);
        int          lat;
        logic [63:0] exp_res;
        exp_res      = ref_div(s, a, b);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        lat          = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                // Operands must be ignored once accepted.
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat(s, a, b)));
        chk({tag, " result"}, result_o, exp_res);
        @(posedge clk);
        #1;
        chk({tag, " hold"}, {result_o[62:0], ready_o}, {exp_res[62:0], 1'b1});
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " release"}, {result_o, 63'd0, ready_o}, 128'd0);
    endtask

    logic        any_rdy;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        run_div("u100/7", 1'b0, 32'd100, 32'd7);
        chk("u100/7 model", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        run_div("s-100/7", 1'b1, 32'hFFFF_FF9C, 32'd7);
        run_div("s_min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("u12345/0", 1'b0, 32'd12345, 32'd0);
        run_div("u5/9", 1'b0, 32'd5, 32'd9);
        run_div("s-5/9", 1'b1, 32'hFFFF_FFFB, 32'd9);

        // Annul at step 10, then an immediate new divide.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        any_rdy      = 1'b0;
        repeat (11) begin
            @(posedge clk);
            #1;
            any_rdy |= ready_o;
        end
        annul_i   = 1'b1;
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        @(posedge clk);
        #1;
        any_rdy |= ready_o;
        chk("annul no ready", 64'(any_rdy), 64'd0);
        chk("annul result", result_o, 64'd0);
        run_div("annul next 9/3", 1'b0, 32'd9, 32'd3);

        // Reset mid-divide with start_i held through release.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd50000;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst outputs", {result_o, 63'd0, ready_o}, 128'd0);
        rst = 1'b0;
        run_div("post-rst s-77/5", 1'b1, 32'hFFFF_FFB3, 32'd5);

        // start_i and annul_i both high in FREE must not be accepted.
        start_i = 1'b1;
        annul_i = 1'b1;
        opdata1_i = 32'd7;
        opdata2_i = 32'd0;
        any_rdy = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            any_rdy |= ready_o;
        end
        chk("start+annul ignored", 64'(any_rdy), 64'd0);
        run_div("after s+a 1000/33", 1'b0, 32'd1000, 32'd33);

        // start_i dropped during ON: result appears for one edge only.
        rs = 1'b1; ra = 32'hFFFF_FC18; rb = 32'd13;
        signed_div_i = rs;
        opdata1_i    = ra;
        opdata2_i    = rb;
        start_i      = 1'b1;
        for (int k = 1; k <= exp_lat(rs, ra, rb); k++) begin
            @(posedge clk);
            #1;
            if (k == 6) start_i = 1'b0;
        end
        chk("drop ready", 64'(ready_o), 64'd1);
        chk("drop result", result_o, ref_div(rs, ra, rb));
        @(posedge clk);
        #1;
        chk("drop discard", {result_o, 63'd0, ready_o}, 128'd0);

        // Randomized divides with biased operand classes.
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1: begin ra = $urandom_range(0, 200); rb = $urandom_range(1, 20); end
                2: rb = 32'd0;
                3: begin ra = 32'h8000_0000; rb = (i % 2 == 0) ? 32'hFFFF_FFFF : $urandom; end
                4: rb = $urandom_range(1, 3);
                default: begin ra = $urandom_range(0, 50); rb = $urandom_range(51, 1000); end
            endcase
            run_div($sformatf("rand%0d", i), rs, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle 32-bit divide sequencer for the EX stage.
- Accepts operands from EX and runs a 32-step radix-2 restoring division.
- Returns {remainder, quotient} for the HI/LO write that travels through the EX/MEM register.
- The EX stage holds its stall request while a divide is busy.

Parameters:
- DATA_W, 32, operand width; fixed by the HI/LO datapath; other values unsupported.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request; EX holds it high until the result is consumed.
- annul_i  in  1  abort the current divide (flush).
- result_o  out  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}; registered.
- ready_o  out  1  result valid; registered.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset: state=FREE, cnt=0, result_o=0, ready_o=0, internal operand registers=0.
- States:
  - FREE: on start_i=1 and annul_i=0, latch the operands. If signed_div_i=1, negative operands are latched as their magnitudes and the original signs are stored.
    - opdata2_i==0 -> BYZERO.
    - Otherwise -> ON with cnt=0 and partial remainder=0.
    - In FREE: ready_o=0 and result_o=0.
  - BYZERO: next edge -> END with quotient=0 and remainder=0.
  - ON: if annul_i=1 -> FREE, ready_o=0, no result produced.
    - Else each edge performs one step: shift {rem,quo} left by 1 and trial-subtract the divisor from rem. If no borrow, the new rem is the difference and the quotient LSB is 1; else rem is unchanged and the LSB is 0. cnt increments.
    - When cnt==32: apply sign correction if signed. Quotient is negated if the operand signs differ; remainder is negated if the dividend was negative. Register result_o, set ready_o=1, and go to END.
  - END: hold result_o and ready_o=1 while start_i=1.
    - start_i=0 -> FREE, ready_o=0, result_o=0.
    - annul_i in END -> FREE, same as start_i=0.
- Latency, counting from the edge that samples start_i:
  - ready_o is high after edge 34 (1 edge to enter ON, 32 step edges, 1 finish edge).
  - Divide-by-zero: ready_o is high after edge 2.
- Boundary cases:
  - Signed 0x80000000 / 0xFFFFFFFF: result wraps to quotient=0x80000000, remainder=0; no trap.
  - Magnitude of 0x80000000 is 0x80000000 taken as unsigned, so the 32-bit datapath needs no extra bit.
  - start_i pulled low during ON without annul_i: the divide still completes and the result is discarded in END on the next edge.
  - Operand inputs are ignored outside FREE.
  - start_i and annul_i both high in FREE: not accepted.
  - rst mid-divide: immediate return to reset values on that edge.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined, in FREE with a nonzero divisor and |dividend| < |divisor| (unsigned compare of the latched magnitudes), go directly to END.
  - Quotient=0; remainder=the original opdata1_i, sign preserved.
  - ready_o is high after edge 2.
- When undefined, these cases take the full 34-edge path with identical results.

Decomposition:
- Shared defines header:
  - State encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
  - DivStart, DivStop, DivResultReady, DivResultNotReady.
  - ZeroWord, RegBus, DoubleRegBus.
- Sub-module div_step: combinational single iteration taking {rem,quo} and the divisor, producing the next {rem,quo}.

Test Plan:
- Unsigned 100 / 7: ready_o after 34 edges, result_o={32'd2, 32'd14}; start_i low -> ready_o=0 and result_o=0 next edge.
- Signed -100 / 7: quotient=0xFFFFFFF2, remainder=0xFFFFFFFE. Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Divide by zero, 12345 / 0: ready_o after edge 2, result_o=0.
- annul_i pulsed at step 10: ready_o never rises, state returns to FREE. An immediate new 9 / 3 gives quotient=3, remainder=0 after 34 edges.
- rst asserted at step 20, then released: all outputs 0. With start_i held high through the release, the new divide begins on the first post-reset edge.
- DIV_EARLY_OUT_EN: unsigned 5 / 9 -> ready_o after edge 2, result_o={32'd5, 32'd0}. Same stimulus without the macro -> identical result after 34 edges.
